// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, one step per cycle,
// with the sign fixup applied as the result is written into HI/LO.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  input  logic        WriteHi,
  input  logic        WriteLo,
  output logic        busy,
  output logic        done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int unsigned W      = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned LAST_I = 31;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div, r_neg_a, r_neg_b, r_div_zero;
  logic [W-1:0]       r_acc_hi, r_acc_lo, r_opnd;
  logic [W-1:0]       r_hi, r_lo;
  logic               r_busy, r_done;

  logic               w_signed, w_accept;
  logic [W-1:0]       w_abs_a, w_abs_b;
  logic [W:0]         w_sum, w_add, w_shift, w_diff;
  logic [W-1:0]       w_acc_hi_nxt, w_acc_lo_nxt;
  logic [2*W-1:0]     w_prod, w_prod_fix;
  logic [W-1:0]       w_quot, w_rem, w_res_hi, w_res_lo;

  assign busy = r_busy;
  assign done = r_done;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

  // Operand capture: magnitudes for signed ops, raw values for unsigned ops
  assign w_signed = ~op[0];
  assign w_accept = (r_state == IDLE) && start;
  assign w_abs_a  = (w_signed && OperandA[W-1]) ? W'(-OperandA) : OperandA;
  assign w_abs_b  = (w_signed && OperandB[W-1]) ? W'(-OperandB) : OperandB;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (r_cnt == CNT_W'(LAST_I)) w_state_next = FINISH;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // One multiply (shift-add) or divide (restoring) step on the accumulator
  always_comb begin
    w_sum   = {1'b0, r_acc_hi} + {1'b0, r_opnd};
    w_add   = r_acc_lo[0] ? w_sum : {1'b0, r_acc_hi};
    w_shift = {r_acc_hi, r_acc_lo[W-1]};
    w_diff  = w_shift - {1'b0, r_opnd};
    if (r_is_div) begin
      if (!w_diff[W]) begin
        w_acc_hi_nxt = w_diff[W-1:0];
        w_acc_lo_nxt = {r_acc_lo[W-2:0], 1'b1};
      end else begin
        w_acc_hi_nxt = w_shift[W-1:0];
        w_acc_lo_nxt = {r_acc_lo[W-2:0], 1'b0};
      end
    end else begin
      w_acc_hi_nxt = w_add[W:1];
      w_acc_lo_nxt = {w_add[0], r_acc_lo[W-1:1]};
    end
  end

  // Sign fixup; divide by zero forces an all-ones quotient
  always_comb begin
    w_prod     = {r_acc_hi, r_acc_lo};
    w_prod_fix = (r_neg_a ^ r_neg_b) ? (2*W)'(-w_prod) : w_prod;
    w_quot     = r_div_zero ? '1 :
                 ((r_neg_a ^ r_neg_b) ? W'(-r_acc_lo) : r_acc_lo);
    w_rem      = r_neg_a ? W'(-r_acc_hi) : r_acc_hi;
    w_res_hi   = r_is_div ? w_rem  : w_prod_fix[2*W-1:W];
    w_res_lo   = r_is_div ? w_quot : w_prod_fix[W-1:0];
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_div_zero <= 1'b0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opnd     <= '0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_is_div   <= op[1];
      r_neg_a    <= w_signed & OperandA[W-1];
      r_neg_b    <= w_signed & OperandB[W-1];
      r_div_zero <= (OperandB == '0);
      r_acc_hi   <= '0;
      r_acc_lo   <= op[1] ? w_abs_a : w_abs_b;
      r_opnd     <= op[1] ? w_abs_b : w_abs_a;
    end else if (r_state == RUN) begin
      r_cnt      <= r_cnt + CNT_W'(1);
      r_acc_hi   <= w_acc_hi_nxt;
      r_acc_lo   <= w_acc_lo_nxt;
    end
  end

  // Architectural HI/LO: result on FINISH, mthi/mtlo only while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == FINISH) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (r_state == IDLE) begin
      if (WriteHi) r_hi <= OperandA;
      if (WriteLo) r_lo <= OperandA;
    end
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == RUN);
      r_done <= (w_state_next == FINISH);
    end
  end

endmodule
